stb_byte_packer: RTL



---
 rtl/stb_byte_packer_pkg.sv | 26 ++
 rtl/stb_byte_packer_fifo.sv | 68 ++++++
 rtl/stb_byte_packer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/stb_byte_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stb_byte_packer_pkg
//  Brief    : Shared control-bit positions, status layout and FSM encoding
//             for the STB byte packer.
//  Revision : 1.0  initial release
// ============================================================================
package stb_byte_packer_pkg;

    localparam int STB_CTRL_FLUSH_BIT  = 0;
    localparam int STB_CTRL_CLEAR_BIT  = 1;
    localparam int STB_CTRL_ENABLE_BIT = 2;

    typedef struct packed {
        logic       partial;
        logic [1:0] count;
        logic [4:0] level;
    } stb_status_t;

    typedef enum logic [0:0] {
        FILL       = 1'b0,
        FLUSH_WAIT = 1'b1
    } stb_packer_state_t;

endpackage
`default_nettype wire

// File: rtl/stb_byte_packer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : stb_fifo
//  Brief    : Synchronous word FIFO with registered pointers, separate level
//             counter and a synchronous clear that overrides push/pop.
//  Revision : 1.0  initial release
// ============================================================================
module stb_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    input  logic                         i_clear,
    output logic [WIDTH-1:0]             o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH + 1);
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full    = (r_level == c_FULL_LVL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    // Head reads as zero when empty so nothing stale leaks after reset or clear
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !i_clear) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/stb_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : stb_byte_packer
//  Brief    : Packs a core byte stream little-endian into 32-bit words and
//             serves them on STB data/status/control ready-valid channels.
//  Revision : 1.0  initial release
// ============================================================================
module stb_byte_packer
    import stb_byte_packer_pkg::*;
#(
    parameter int DEPTH             = 8,
    parameter int STB_DATA_WIDTH    = 32,
    parameter int STB_STATUS_WIDTH  = 8,
    parameter int STB_CONTROL_WIDTH = 8
) (
    input  logic                         CLK_I,
    input  logic                         RST_NI,
    input  logic                         BYTE_VALID_I,
    output logic                         BYTE_READY_O,
    input  logic [7:0]                   BYTE_I,
    output logic                         STB_DATA_VALID_O,
    input  logic                         STB_DATA_READY_I,
    output logic [STB_DATA_WIDTH-1:0]    STB_DATA_O,
    output logic                         STB_STATUS_VALID_O,
    input  logic                         STB_STATUS_READY_I,
    output logic [STB_STATUS_WIDTH-1:0]  STB_STATUS_O,
    input  logic                         STB_CONTROL_VALID_I,
    output logic                         STB_CONTROL_READY_O,
    input  logic [STB_CONTROL_WIDTH-1:0] STB_CONTROL_I
);

    localparam int c_LVL_W = $clog2(DEPTH + 1);

    stb_packer_state_t         r_state, w_state_nxt;
    logic                      r_alive;
    logic                      r_enable, w_enable_nxt;
    logic [1:0]                r_cnt, w_cnt_nxt;
    logic [STB_DATA_WIDTH-1:0] r_asm, w_asm_nxt;
    logic                      w_push;
    logic [STB_DATA_WIDTH-1:0] w_push_data;
    logic                      w_clear;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic [c_LVL_W-1:0]        w_level;
    logic                      w_ctrl_fire;
    logic                      w_byte_fire;
    logic                      w_flush_cmd;
    logic                      w_clear_cmd;
    stb_status_t               w_status;
    logic                      w_unused_ok;

    assign w_flush_cmd = STB_CONTROL_I[STB_CTRL_FLUSH_BIT];
    assign w_clear_cmd = STB_CONTROL_I[STB_CTRL_CLEAR_BIT];

    assign STB_CONTROL_READY_O = (r_state == FILL);
    assign w_ctrl_fire         = STB_CONTROL_VALID_I && STB_CONTROL_READY_O;

    // Bytes are held off while a flush/clear is offered so the two never race
    assign BYTE_READY_O = r_alive && r_enable && (r_state == FILL)
                        && !(STB_CONTROL_VALID_I && (w_flush_cmd || w_clear_cmd))
                        && ((r_cnt != 2'd3) || !w_full);
    assign w_byte_fire  = BYTE_VALID_I && BYTE_READY_O;

    assign STB_DATA_VALID_O   = !w_empty;
    assign w_pop              = STB_DATA_VALID_O && STB_DATA_READY_I;
    assign STB_STATUS_VALID_O = r_alive;

    always_comb begin
        w_status         = '0;
        w_status.partial = (r_cnt != 2'd0);
        w_status.count   = r_cnt;
        w_status.level   = 5'(w_level);
    end
    assign STB_STATUS_O = w_status;

    assign w_unused_ok = &{1'b0, STB_STATUS_READY_I, STB_CONTROL_I[STB_CONTROL_WIDTH-1:3]};

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_state  <= FILL;
            r_alive  <= 1'b0;
            r_enable <= 1'b1;
            r_cnt    <= 2'd0;
            r_asm    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_alive  <= 1'b1;
            r_enable <= w_enable_nxt;
            r_cnt    <= w_cnt_nxt;
            r_asm    <= w_asm_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_enable_nxt = r_enable;
        w_cnt_nxt    = r_cnt;
        w_asm_nxt    = r_asm;
        w_push       = 1'b0;
        w_push_data  = r_asm;
        w_clear      = 1'b0;
        unique case (r_state)
            FILL: begin
                if (w_ctrl_fire) begin
                    w_enable_nxt = STB_CONTROL_I[STB_CTRL_ENABLE_BIT];
                    if (w_clear_cmd) begin
                        w_clear   = 1'b1;
                        w_cnt_nxt = 2'd0;
                        w_asm_nxt = '0;
                    end else if (w_flush_cmd && (r_cnt != 2'd0)) begin
                        if (!w_full) begin
                            w_push    = 1'b1;
                            w_cnt_nxt = 2'd0;
                            w_asm_nxt = '0;
                        end else begin
                            w_state_nxt = FLUSH_WAIT;
                        end
                    end
                end
                if (w_byte_fire) begin
                    if (r_cnt == 2'd3) begin
                        w_push      = 1'b1;
                        w_push_data = {BYTE_I, r_asm[STB_DATA_WIDTH-9:0]};
                        w_cnt_nxt   = 2'd0;
                        w_asm_nxt   = '0;
                    end else begin
                        w_asm_nxt[8*r_cnt +: 8] = BYTE_I;
                        w_cnt_nxt               = r_cnt + 2'd1;
                    end
                end
            end
            FLUSH_WAIT: begin
                // Upper bytes of asm are already zero, so it is the padded word
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_cnt_nxt   = 2'd0;
                    w_asm_nxt   = '0;
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    stb_fifo #(
        .WIDTH (STB_DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (CLK_I),
        .rst_n       (RST_NI),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_clear     (w_clear),
        .o_head      (STB_DATA_O),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level)
    );

endmodule
`default_nettype wire
